// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters: round-robin grant, issue, wait, tagged response.
// Optional macro ALU_REQ_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module alu_req_arbiter #(
  parameter  int NUM_REQ     = 2,
  parameter  int ALU_LATENCY = 1,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*5-1:0]    req_a,
  input  logic [NUM_REQ*5-1:0]    req_b,
  input  logic [NUM_REQ*7-1:0]    req_op,
  output logic                    ALU_en,
  output logic                    a_en,
  output logic                    b_en,
  output logic [2:0]              a_op,
  output logic [1:0]              b_op,
  output logic signed [4:0]       A,
  output logic signed [4:0]       B,
  input  logic signed [5:0]       C,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic signed [5:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ALU_LATENCY - 1);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        wait_cnt_reg, wait_cnt_next;
  logic [ID_W-1:0]         id_reg, id_next;
  logic                    alu_en_reg, alu_en_next;
  logic                    a_en_reg, a_en_next;
  logic                    b_en_reg, b_en_next;
  logic [2:0]              a_op_reg, a_op_next;
  logic [1:0]              b_op_reg, b_op_next;
  logic signed [4:0]       a_reg, a_next;
  logic signed [4:0]       b_reg, b_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic signed [5:0]       rsp_data_reg, rsp_data_next;
  logic [ID_W-1:0]         rsp_id_reg, rsp_id_next;

  logic [4:0]              op_a   [NUM_REQ];
  logic [4:0]              op_b   [NUM_REQ];
  logic [6:0]              op_ctl [NUM_REQ];
  logic                    grant_found;
  logic [ID_W-1:0]         grant_idx;
  logic [ID_W:0]           cand;
  logic [ID_W-1:0]         search_base;
  logic                    accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_a[gi]      = req_a[5*gi +: 5];
      assign op_b[gi]      = req_b[5*gi +: 5];
      assign op_ctl[gi]    = req_op[7*gi +: 7];
      assign req_ready[gi] = rst_n && accept && (grant_idx == ID_W'(gi));
    end
  endgenerate

`ifdef ALU_REQ_ARB_FIXED_PRIO_EN
  assign search_base = '0;
`else
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);
  logic [ID_W-1:0] rr_ptr_reg;

  // Pointer moves just past the winner so the winner becomes lowest priority next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
    end else if (accept) begin
      rr_ptr_reg <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
    end
  end

  assign search_base = rr_ptr_reg;
`endif

  // Rotating search starting at search_base, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, search_base} + (ID_W + 1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign accept = (state_reg == S_IDLE) && grant_found;

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    id_next        = id_reg;
    alu_en_next    = alu_en_reg;
    a_en_next      = a_en_reg;
    b_en_next      = b_en_reg;
    a_op_next      = a_op_reg;
    b_op_next      = b_op_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_id_next    = rsp_id_reg;
    unique case (state_reg)
      S_IDLE: begin
        // ALU inputs are loaded at acceptance so they are already valid during ISSUE.
        if (accept) begin
          state_next  = S_ISSUE;
          id_next     = grant_idx;
          a_next      = op_a[grant_idx];
          b_next      = op_b[grant_idx];
          a_en_next   = op_ctl[grant_idx][6];
          b_en_next   = op_ctl[grant_idx][5];
          a_op_next   = op_ctl[grant_idx][4:2];
          b_op_next   = op_ctl[grant_idx][1:0];
          alu_en_next = 1'b1;
        end
      end
      S_ISSUE: begin
        state_next    = S_WAIT;
        wait_cnt_next = WAIT_INIT;
      end
      S_WAIT: begin
        if (wait_cnt_reg == '0) begin
          state_next     = S_RESP;
          rsp_data_next  = C;
          rsp_id_next    = id_reg;
          rsp_valid_next = 1'b1;
          alu_en_next    = 1'b0;
          a_en_next      = 1'b0;
          b_en_next      = 1'b0;
        end else begin
          wait_cnt_next = wait_cnt_reg - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_next     = S_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= '0;
      id_reg        <= '0;
      alu_en_reg    <= 1'b0;
      a_en_reg      <= 1'b0;
      b_en_reg      <= 1'b0;
      a_op_reg      <= '0;
      b_op_reg      <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      id_reg        <= id_next;
      alu_en_reg    <= alu_en_next;
      a_en_reg      <= a_en_next;
      b_en_reg      <= b_en_next;
      a_op_reg      <= a_op_next;
      b_op_reg      <= b_op_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_id_reg    <= rsp_id_next;
    end
  end

  assign ALU_en    = alu_en_reg;
  assign a_en      = a_en_reg;
  assign b_en      = b_en_reg;
  assign a_op      = a_op_reg;
  assign b_op      = b_op_reg;
  assign A         = a_reg;
  assign B         = b_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one registered ALU between NUM_REQ independent requesters.
- Each requester posts an operation (operands plus a_en/b_en/a_op/b_op) with a valid/ready handshake.
- The block grants round-robin, drives the ALU control/operand inputs for one operation at a time, and waits the ALU latency.
- It captures C and returns it on a shared response channel tagged with the requester index.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ALU_LATENCY, 1, cycles from the ISSUE clock edge until C is valid; legal range 1..7.
- ID_W (localparam), $clog2(NUM_REQ), width of the response tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_ready  out  NUM_REQ  request accepted when valid&ready.
- req_a  in  NUM_REQ*5  signed operand A per requester; requester i at [5i+4:5i].
- req_b  in  NUM_REQ*5  signed operand B per requester; same packing as req_a.
- req_op  in  NUM_REQ*7  per requester {a_en,b_en,a_op[2:0],b_op[1:0]} at [7i+6:7i].
- ALU_en  out  1  ALU enable.
- a_en  out  1  to ALU.
- b_en  out  1  to ALU.
- a_op  out  3  to ALU.
- b_op  out  2  to ALU.
- A  out  5  signed, to ALU.
- B  out  5  signed, to ALU.
- C  in  6  signed ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_data  out  6  signed captured C.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - ALU_en, a_en, b_en, a_op, b_op, A, B, rsp_valid, rsp_data, rsp_id and busy all 0.
  - req_ready=0 while rst_n=0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready = grant one-hot (combinational; only in IDLE; at most one bit high).
  - On acceptance: latch the granted operands/op/index, set rr_ptr = (i+1) mod NUM_REQ, go to ISSUE.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- ISSUE (1 cycle):
  - ALU_en=1; A, B, a_en, b_en, a_op, b_op driven from the latched values.
  - Go to WAIT with wait_cnt = ALU_LATENCY-1.
- WAIT (ALU_LATENCY cycles):
  - ALU_en and all operand/op outputs held stable.
  - Decrement wait_cnt each cycle.
  - At wait_cnt==0: at that clock edge set rsp_data<=C, rsp_id<=latched index, rsp_valid<=1, ALU_en<=0, a_en<=0, b_en<=0; go to RESP.
- RESP:
  - rsp_valid held high; rsp_data and rsp_id held stable until rsp_ready=1.
  - On handshake: rsp_valid<=0, go to IDLE.
  - No new request is accepted in RESP; there is no bypass from RESP to ISSUE.
- Outputs between operations: A, B, a_op, b_op keep their last values; ALU_en, a_en and b_en are 0 outside ISSUE/WAIT.
- Latency: acceptance in cycle T -> ISSUE in T+1 -> rsp_valid in T+2+ALU_LATENCY. Minimum occupancy is 3+ALU_LATENCY cycles per operation.
- Handshake rules: requesters must hold req_valid and data stable until accepted. The block never drops an accepted request except on reset.
- Arithmetic: none internally; C is passed through unmodified in all 6 bits, sign preserved.
- Boundaries:
  - Single requester always valid: granted every operation.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - req_valid deasserted in the same IDLE cycle it would be granted: no grant.
  - rsp_ready=1 in the same cycle rsp_valid first rises: completes that cycle.
- Reset mid-operation (any state): the operation is aborted, no response is produced, and the block returns to the reset values above.

Optional Feature:
- Macro: ALU_REQ_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest index with req_valid=1 wins; rr_ptr logic is removed.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single op:
  - Stimulus: req0 with A=3, B=6, op a_en=1, b_en=1, b_op=0, accepted at T, rsp_ready=1.
  - Response: ALU_en=1 in T+1..T+2 with A=3, B=6; rsp_valid at T+3 with rsp_data[4:0]=5'b00101 and rsp_id=0.
- Contention, NUM_REQ=2:
  - Stimulus: req0 and req1 continuously valid, rsp_ready=1.
  - Response: grants alternate 0,1,0,1; one acceptance every 4 cycles; req_ready is never two-hot.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid rises.
  - Response: rsp_valid, rsp_data and rsp_id stable; req_ready=0; ALU_en=0 throughout; a new grant in the cycle after rsp_ready=1.
- Reset in WAIT:
  - Stimulus: rst_n pulsed low while busy=1.
  - Response: all outputs 0 immediately; no response issued; with both requesters valid afterwards, the first grant goes to requester 0.
- ALU_LATENCY=3:
  - Stimulus: req1 with B=5, b_op=3, a_en=1, b_en=1.
  - Response: C sampled exactly 3 edges after ISSUE; rsp_data=7, rsp_id=1; ALU inputs stable for 4 cycles.
- ALU_REQ_ARB_FIXED_PRIO_EN defined:
  - Stimulus: req0 and req1 both always valid.
  - Response: every grant goes to requester 0; req1 is granted only after req0 drops valid.
